button_event_regs: RTL and testbench



---
 rtl/button_event_pkg.sv | 32 +++
 rtl/button_event_regs_if.sv | 29 ++
 rtl/button_edge_counter.sv | 49 ++++
 rtl/button_event_regs.sv | 97 +++++++++
 tb/tb_button_event_regs.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/button_event_pkg.sv
`default_nettype none
// ============================================================================
// Module   : button_event_pkg
// Purpose  : Register map, field offsets and pending/mask vector type
// Revision : 1.0
// ============================================================================
package button_event_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_PENDING = 3'd1;
  localparam logic [2:0] ADDR_MASK    = 3'd2;
  localparam logic [2:0] ADDR_COUNT   = 3'd3;

  localparam int PRESS_LSB   = 0;
  localparam int RELEASE_LSB = 4;
  localparam int PEND_W      = 16;

  typedef logic [PEND_W-1:0] pend_vec_t;

  // Bits of PENDING/MASK that exist for n channels; all others read 0.
  function automatic pend_vec_t field_mask(input int n);
    pend_vec_t m;
    m = '0;
    for (int i = 0; i < n; i++) begin
      m[PRESS_LSB+i]   = 1'b1;
      m[RELEASE_LSB+i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_regs_if.sv
`default_nettype none
// ============================================================================
// Module   : button_event_regs_if
// Purpose  : Single-cycle register bus between CPU and button event block
// Revision : 1.0
// ============================================================================
interface button_event_regs_if #(
  parameter int DATA_W = 32
) ();

  logic [2:0]        addr_i;
  logic              we_i;
  logic              re_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;
  logic              rvalid_o;

  modport master (
    output addr_i, we_i, re_i, wdata_i,
    input  rdata_o, rvalid_o
  );

  modport slave (
    input  addr_i, we_i, re_i, wdata_i,
    output rdata_o, rvalid_o
  );

endinterface
`default_nettype wire

// File: rtl/button_edge_counter.sv
`default_nettype none
// ============================================================================
// Module   : button_edge_counter
// Purpose  : Per-channel press/release edge detect and saturating press count
// Revision : 1.0
// ============================================================================
module button_edge_counter #(
  parameter int CNT_W = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             btn_i,
  input  wire logic             clr_i,
  output logic                  press_o,
  output logic                  release_o,
  output logic [CNT_W-1:0]      count_o
);

  logic             prev_q,  prev_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] count_base;

  always_comb begin
    prev_d     = btn_i;
    press_o    = btn_i & ~prev_q;
    release_o  = ~btn_i & prev_q;
    // Clear is applied first so a coincident press still counts.
    count_base = clr_i ? '0 : count_q;
    count_d    = count_base;
    if (press_o && (count_base != {CNT_W{1'b1}})) begin
      count_d = count_base + 1'b1;
    end
  end

  // prev tracks the live level during reset so a held button is not an event.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= btn_i;
      count_q <= '0;
    end else begin
      prev_q  <= prev_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/button_event_regs.sv
`default_nettype none
// ============================================================================
// Module   : button_event_regs
// Purpose  : Sticky W1C button events, press counters, masked level interrupt
// Revision : 1.0
// ============================================================================
module button_event_regs
  import button_event_pkg::*;
#(
  parameter int N_BTN  = 4,
  parameter int CNT_W  = 8,
  parameter int DATA_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [N_BTN-1:0] btn_i,
  button_event_regs_if.slave    bus,
  output logic                  irq_o
);

  localparam pend_vec_t VALID_BITS = field_mask(N_BTN);

  logic [N_BTN-1:0]  press, rel;
  logic [CNT_W-1:0]  cnt [N_BTN];
  logic              cnt_clr;
  pend_vec_t         pend_q, pend_d, mask_q, mask_d, events, w1c;
  logic [DATA_W-1:0] rdata_q, rdata_d, count_word;
  logic              rvalid_q, irq_q, irq_d;
  logic              unused_wdata;

  assign cnt_clr      = bus.we_i && (bus.addr_i == ADDR_COUNT);
  assign unused_wdata = ^bus.wdata_i[DATA_W-1:PEND_W];

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_edge_counter #(.CNT_W(CNT_W)) u_ch (
        .clk       (clk),
        .rst       (rst),
        .btn_i     (btn_i[i]),
        .clr_i     (cnt_clr),
        .press_o   (press[i]),
        .release_o (rel[i]),
        .count_o   (cnt[i])
      );
    end
  endgenerate

  always_comb begin
    events     = '0;
    count_word = '0;
    for (int i = 0; i < N_BTN; i++) begin
      events[PRESS_LSB+i]      = events[PRESS_LSB+i] | press[i];
      events[RELEASE_LSB+i]    = events[RELEASE_LSB+i] | rel[i];
      count_word[i*CNT_W +: CNT_W] = cnt[i];
    end

    w1c = (bus.we_i && (bus.addr_i == ADDR_PENDING)) ? bus.wdata_i[PEND_W-1:0] : '0;
    // New events are ORed in after the clear so a colliding W1C never loses one.
    pend_d = ((pend_q & ~w1c) | events) & VALID_BITS;
    mask_d = (bus.we_i && (bus.addr_i == ADDR_MASK))
             ? (bus.wdata_i[PEND_W-1:0] & VALID_BITS) : mask_q;
    irq_d  = |(pend_d & mask_d);

    rdata_d = rdata_q;
    if (bus.re_i) begin
      case (bus.addr_i)
        ADDR_STATUS:  rdata_d = DATA_W'(btn_i);
        ADDR_PENDING: rdata_d = DATA_W'(pend_q);
        ADDR_MASK:    rdata_d = DATA_W'(mask_q);
        ADDR_COUNT:   rdata_d = count_word;
        default:      rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      rdata_q  <= rdata_d;
      rvalid_q <= bus.re_i;
      irq_q    <= irq_d;
    end
  end

  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;
  assign irq_o        = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_regs
// Purpose  : Directed self-checking bench for button_event_regs
// Revision : 1.0
// ============================================================================
module tb_button_event_regs;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic       irq;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  button_event_regs_if #(.DATA_W(32)) bus ();

  button_event_regs #(.N_BTN(4), .CNT_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn_i (btn),
    .bus   (bus),
    .irq_o (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Expected read data is queued at issue and retired when rvalid_o is due.
  task automatic read_reg(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    bus.addr_i = a;
    bus.re_i   = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    bus.re_i = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, bus.rvalid_o}, 32'd1);
    chk(tag, bus.rdata_o, exp_q.pop_front());
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.addr_i  = a;
    bus.wdata_i = d;
    bus.we_i    = 1'b1;
    @(negedge clk);
    bus.we_i = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    btn         = 4'b0010;
    bus.addr_i  = '0;
    bus.we_i    = 1'b0;
    bus.re_i    = 1'b0;
    bus.wdata_i = '0;

    // Reset with button 1 held through release
    repeat (3) @(negedge clk);
    chk("rst_rdata", bus.rdata_o, 32'h0);
    chk("rst_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    read_reg(3'd1, 32'h0, "pend_after_rst");
    chk("irq_after_rst", {31'b0, irq}, 32'h0);

    // Drop button 1, clear its release event
    btn = 4'b0000;
    write_reg(3'd1, 32'h20);
    read_reg(3'd1, 32'h0, "pend_cleared");

    // Press/release with interrupt enabled on press 0
    write_reg(3'd2, 32'h01);
    chk("irq_before_press", {31'b0, irq}, 32'h0);
    btn[0] = 1'b1;
    @(negedge clk);
    chk("irq_on_press", {31'b0, irq}, 32'h1);
    repeat (4) @(negedge clk);
    btn[0] = 1'b0;
    @(negedge clk);
    read_reg(3'd1, 32'h11, "pend_press_rel");
    @(negedge clk);
    chk("rdata_hold", bus.rdata_o, 32'h11);
    chk("rvalid_pulse", {31'b0, bus.rvalid_o}, 32'h0);
    read_reg(3'd3, 32'h0000_0001, "count_one");
    write_reg(3'd1, 32'h01);
    chk("irq_after_w1c", {31'b0, irq}, 32'h0);
    read_reg(3'd1, 32'h10, "pend_after_w1c");

    // W1C of bit 1 coincident with its press
    @(negedge clk);
    btn[1]      = 1'b1;
    bus.addr_i  = 3'd1;
    bus.wdata_i = 32'h02;
    bus.we_i    = 1'b1;
    @(negedge clk);
    bus.we_i = 1'b0;
    read_reg(3'd1, 32'h12, "w1c_collision");

    // Saturate counter 3
    repeat (300) begin
      @(negedge clk);
      btn[3] = 1'b1;
      @(negedge clk);
      btn[3] = 1'b0;
    end
    read_reg(3'd3, 32'hFF00_0101, "count_sat");

    // Counter clear coincident with press on button 2
    @(negedge clk);
    btn[2]      = 1'b1;
    bus.addr_i  = 3'd3;
    bus.wdata_i = 32'h0;
    bus.we_i    = 1'b1;
    @(negedge clk);
    bus.we_i = 1'b0;
    read_reg(3'd3, 32'h0001_0000, "count_clr_press");

    read_reg(3'd5, 32'h0, "unmapped");
    read_reg(3'd0, 32'h6, "status");

    // Read and write MASK in the same cycle
    @(negedge clk);
    bus.addr_i  = 3'd2;
    bus.wdata_i = 32'hFF;
    bus.we_i    = 1'b1;
    bus.re_i    = 1'b1;
    exp_q.push_back(32'h01);
    @(negedge clk);
    bus.we_i = 1'b0;
    bus.re_i = 1'b0;
    chk("rw_rvalid", {31'b0, bus.rvalid_o}, 32'h1);
    chk("rw_old_mask", bus.rdata_o, exp_q.pop_front());
    chk("irq_mask_all", {31'b0, irq}, 32'h1);
    read_reg(3'd2, 32'hFF, "mask_new");
    read_reg(3'd1, 32'h9E, "pend_accum");

    // Reset mid-operation, colliding with a read
    @(negedge clk);
    rst        = 1'b1;
    bus.addr_i = 3'd1;
    bus.re_i   = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    bus.re_i = 1'b0;
    chk("midrst_rvalid", {31'b0, bus.rvalid_o}, 32'h0);
    chk("midrst_rdata", bus.rdata_o, 32'h0);
    chk("midrst_irq", {31'b0, irq}, 32'h0);
    read_reg(3'd1, 32'h0, "midrst_pend");
    read_reg(3'd2, 32'h0, "midrst_mask");
    read_reg(3'd3, 32'h0, "midrst_count");
    chk("midrst_irq_after", {31'b0, irq}, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
